// File: rtl/fpu_mul_norm_round_if.sv
// Valid/ready bundle for the FPU multiplier normalise/round stage: upstream beat
// fields plus downstream result and exception flags.
interface fpu_mul_norm_round_if #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_EXP  = 8
);
    localparam int P_W = 2 * SIZE_DATA;
    localparam int E_W = SIZE_EXP + 2;
    localparam int R_W = SIZE_EXP + SIZE_DATA;

    // Upstream side
    logic           i_valid;
    logic           o_ready;
    logic [P_W-1:0] i_product;
    logic           i_sign;
    logic [E_W-1:0] i_exp_sum;
    logic           i_is_zero;
    logic           i_is_inf;
    logic           i_is_nan;

    // Downstream side
    logic           o_valid;
    logic           i_ready;
    logic [R_W-1:0] o_result;
    logic           o_overflow;
    logic           o_underflow;
    logic           o_inexact;

    modport slave (
        input  i_valid, i_product, i_sign, i_exp_sum, i_is_zero, i_is_inf, i_is_nan,
        input  i_ready,
        output o_ready,
        output o_valid, o_result, o_overflow, o_underflow, o_inexact
    );

    modport master (
        output i_valid, i_product, i_sign, i_exp_sum, i_is_zero, i_is_inf, i_is_nan,
        output i_ready,
        input  o_ready,
        input  o_valid, o_result, o_overflow, o_underflow, o_inexact
    );
endinterface

// File: rtl/fpu_mul_norm_round.sv
// Post-multiply normalise (stage 1) and round/pack (stage 2) for binary32, denormals flushed.
// Define FPU_MUL_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fpu_mul_norm_round #(
    parameter int SIZE_DATA = 24,  // only 24 supported
    parameter int SIZE_EXP  = 8    // only 8 supported
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fpu_mul_norm_round_if.slave  bus
);
    localparam int P_W    = 2 * SIZE_DATA;
    localparam int FRAC_W = SIZE_DATA - 1;
    localparam int E_W    = SIZE_EXP + 2;
    localparam int R_W    = SIZE_EXP + SIZE_DATA;

    localparam logic signed [E_W-1:0] EXP_MAX   = E_W'((1 << SIZE_EXP) - 1);
    localparam logic signed [E_W-1:0] EXP_MIN   = '0;
    localparam logic [SIZE_EXP-1:0]   EXP_ONES  = '1;
    localparam logic [SIZE_EXP-1:0]   EXP_ZERO  = '0;
    localparam logic [FRAC_W-1:0]     FRAC_ZERO = '0;
    localparam logic [R_W-1:0]        QNAN      = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake: each stage moves when the stage after it can take a beat.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic out_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv      = !out_valid || bus.i_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.o_ready = s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: pick the leading one (bit 47 or 46) and split guard/round/sticky.
    // ------------------------------------------------------------------
    logic [FRAC_W-1:0] n_frac;
    logic              n_g;
    logic              n_r;
    logic              n_s;
    logic [E_W-1:0]    n_exp;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        n_frac = bus.i_product[P_W-3 -: FRAC_W];
        n_g    = bus.i_product[P_W-3-FRAC_W];
        n_r    = bus.i_product[P_W-4-FRAC_W];
        n_s    = |bus.i_product[P_W-5-FRAC_W:0];
        n_exp  = bus.i_exp_sum;
        if (bus.i_product[P_W-1]) begin
            n_frac = bus.i_product[P_W-2 -: FRAC_W];
            n_g    = bus.i_product[P_W-2-FRAC_W];
            n_r    = bus.i_product[P_W-3-FRAC_W];
            n_s    = |bus.i_product[P_W-4-FRAC_W:0];
            n_exp  = bus.i_exp_sum + E_W'(1);
        end
    end

    logic [FRAC_W-1:0]     s1_frac;
    logic                  s1_g;
    logic                  s1_r;
    logic                  s1_s;
    logic signed [E_W-1:0] s1_exp;
    logic                  s1_sign;
    logic                  s1_zero;
    logic                  s1_inf;
    logic                  s1_nan;

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge i_clk) begin
        if (s1_adv && bus.i_valid) begin
            s1_frac <= n_frac;
            s1_g    <= n_g;
            s1_r    <= n_r;
            s1_s    <= n_s;
            s1_exp  <= n_exp;
            s1_sign <= bus.i_sign;
            s1_zero <= bus.i_is_zero;
            s1_inf  <= bus.i_is_inf;
            s1_nan  <= bus.i_is_nan;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, then apply special-case / range priority.
    // ------------------------------------------------------------------
    logic [FRAC_W-1:0]     frac_rnd;
    logic signed [E_W-1:0] exp_rnd;
    logic                  inexact;

`ifdef FPU_MUL_ROUND_EN
    logic              inc;
    logic [FRAC_W:0]   frac_sum;

    assign inc      = s1_g && (s1_r || s1_s || s1_frac[0]);
    assign frac_sum = {1'b0, s1_frac} + {{FRAC_W{1'b0}}, inc};
    // A carry out leaves the low bits all-zero, which is exactly the renormalised 1.0.
    assign frac_rnd = frac_sum[FRAC_W-1:0];
    assign exp_rnd  = s1_exp + {{(E_W-1){1'b0}}, frac_sum[FRAC_W]};
`else
    assign frac_rnd = s1_frac;
    assign exp_rnd  = s1_exp;
`endif

    assign inexact = s1_g || s1_r || s1_s;

    logic [R_W-1:0] res_d;
    logic           ov_d;
    logic           un_d;
    logic           ix_d;

    always_comb begin
        res_d = {s1_sign, exp_rnd[SIZE_EXP-1:0], frac_rnd};
        ov_d  = 1'b0;
        un_d  = 1'b0;
        ix_d  = inexact;
        if (s1_nan || (s1_inf && s1_zero)) begin
            res_d = QNAN;
            ix_d  = 1'b0;
        end else if (s1_inf) begin
            res_d = {s1_sign, EXP_ONES, FRAC_ZERO};
            ix_d  = 1'b0;
        end else if (s1_zero) begin
            res_d = {s1_sign, EXP_ZERO, FRAC_ZERO};
            ix_d  = 1'b0;
        end else if (exp_rnd >= EXP_MAX) begin
            res_d = {s1_sign, EXP_ONES, FRAC_ZERO};
            ov_d  = 1'b1;
            ix_d  = 1'b1;
        end else if (exp_rnd <= EXP_MIN) begin
            res_d = {s1_sign, EXP_ZERO, FRAC_ZERO};
            un_d  = 1'b1;
            ix_d  = 1'b1;
        end
    end

    logic [R_W-1:0] out_result;
    logic           out_ov;
    logic           out_un;
    logic           out_ix;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ov     <= 1'b0;
            out_un     <= 1'b0;
            out_ix     <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= bus.i_valid;
            if (s2_adv) out_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                out_result <= res_d;
                out_ov     <= ov_d;
                out_un     <= un_d;
                out_ix     <= ix_d;
            end
        end
    end

    assign bus.o_valid     = out_valid;
    assign bus.o_result    = out_result;
    assign bus.o_overflow  = out_ov;
    assign bus.o_underflow = out_un;
    assign bus.o_inexact   = out_ix;
endmodule
